line_buffer_3x3: RTL and testbench



---
 rtl/edge_det_pkg.sv | 24 ++
 rtl/line_buffer_3x3_if.sv | 28 ++
 rtl/line_buffer_3x3_line_mem.sv | 23 ++
 rtl/line_buffer_3x3.sv | 134 +++++++++++++
 tb/tb_line_buffer_3x3.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/edge_det_pkg.sv
// Shared constants for the luma line buffer and the edge-detection kernel.
// Window slice indices count pixels from the LSB end: p22 (current pixel) is slice 0.
package edge_det_pkg;

    localparam int PIX_W        = 8;
    localparam int WIN_W        = 9 * PIX_W;
    localparam int LB_MAX_WIDTH = 640;
    localparam int LB_CNT_W     = 12;

    localparam int P00 = 8;
    localparam int P01 = 7;
    localparam int P02 = 6;
    localparam int P10 = 5;
    localparam int P11 = 4;
    localparam int P12 = 3;
    localparam int P20 = 2;
    localparam int P21 = 1;
    localparam int P22 = 0;

    function automatic logic [PIX_W-1:0] win_pix(input logic [WIN_W-1:0] win, input int idx);
        return win[idx*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/line_buffer_3x3_if.sv
// Pixel-in / window-out bundle of the 3x3 line buffer.
// slave = line buffer side, master = upstream source / downstream consumer side.
interface line_buffer_3x3_if #(
    parameter int CNT_W = edge_det_pkg::LB_CNT_W
);
    logic [edge_det_pkg::PIX_W-1:0] I_PIX;
    logic                           I_DE;
    logic                           I_HSYNC;
    logic                           I_VSYNC;
    logic [edge_det_pkg::WIN_W-1:0] O_WIN;
    logic                           O_WIN_VALID;
    logic                           O_DE;
    logic                           O_HSYNC;
    logic                           O_VSYNC;
    logic [CNT_W-1:0]               O_COL;
    logic [CNT_W-1:0]               O_ROW;
    logic                           O_OVF;

    modport slave (
        input  I_PIX, I_DE, I_HSYNC, I_VSYNC,
        output O_WIN, O_WIN_VALID, O_DE, O_HSYNC, O_VSYNC, O_COL, O_ROW, O_OVF
    );

    modport master (
        output I_PIX, I_DE, I_HSYNC, I_VSYNC,
        input  O_WIN, O_WIN_VALID, O_DE, O_HSYNC, O_VSYNC, O_COL, O_ROW, O_OVF
    );
endinterface

// File: rtl/line_buffer_3x3_line_mem.sv
// One line of luma: combinational read, synchronous write at the same address (read-before-write).
// Contents are deliberately not reset; the valid gating upstream hides stale data.
module line_mem #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdat,
    output logic [PIX_W-1:0] rdat
);
    logic [PIX_W-1:0] mem_q [DEPTH];

    assign rdat = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdat;
        end
    end
endmodule

// File: rtl/line_buffer_3x3.sv
// 3x3 luma window generator with two line memories; window, sync and counters are 1 cycle behind the input.
// No backpressure: one pixel per DE cycle; pixels beyond MAX_WIDTH are dropped and flagged. Option: LB_BORDER_ZERO_EN.
module line_buffer_3x3
    import edge_det_pkg::*;
#(
    parameter int MAX_WIDTH = LB_MAX_WIDTH,
    parameter int CNT_W     = LB_CNT_W
) (
    input  logic        I_PCLK,
    input  logic        I_RST_N,
    line_buffer_3x3_if.slave bus
);
    localparam int               AW      = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [CNT_W-1:0] MAX_COL = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] col_q, col_d, row_q, row_d, col_eff, row_eff;
    logic [CNT_W-1:0] o_col_q, o_col_d, o_row_q, o_row_d;
    logic [WIN_W-1:0] win_q, win_d, o_win_q, o_win_d;
    logic             de_q, vs_q, ovf_q, ovf_d;
    logic             o_win_valid_q, o_win_valid_d;
    logic             o_de_q, o_hsync_q, o_vsync_q;
    logic             frame_start, accept, line_end;
    logic [AW-1:0]    addr;
    logic [PIX_W-1:0] lm_a, lm_b;

    always_comb begin
        frame_start = bus.I_VSYNC && !vs_q;
        // A frame start in the same cycle as a pixel places that pixel at (0,0).
        col_eff     = frame_start ? '0 : col_q;
        row_eff     = frame_start ? '0 : row_q;
        accept      = bus.I_DE && (col_eff < MAX_COL);
        line_end    = !bus.I_DE && de_q && !frame_start;
        addr        = col_eff[AW-1:0];

        col_d         = col_eff;
        row_d         = row_eff;
        ovf_d         = frame_start ? 1'b0 : ovf_q;
        win_d         = win_q;
        o_col_d       = o_col_q;
        o_row_d       = o_row_q;
        o_win_valid_d = accept && (row_eff >= TWO) && (col_eff >= TWO);

        if (accept) begin
            win_d[P00*PIX_W +: PIX_W] = win_pix(win_q, P01);
            win_d[P01*PIX_W +: PIX_W] = win_pix(win_q, P02);
            win_d[P02*PIX_W +: PIX_W] = lm_b;
            win_d[P10*PIX_W +: PIX_W] = win_pix(win_q, P11);
            win_d[P11*PIX_W +: PIX_W] = win_pix(win_q, P12);
            win_d[P12*PIX_W +: PIX_W] = lm_a;
            win_d[P20*PIX_W +: PIX_W] = win_pix(win_q, P21);
            win_d[P21*PIX_W +: PIX_W] = win_pix(win_q, P22);
            win_d[P22*PIX_W +: PIX_W] = bus.I_PIX;
            col_d   = col_eff + ONE;
            o_col_d = col_eff;
            o_row_d = row_eff;
        end else if (bus.I_DE) begin
            ovf_d = 1'b1;
        end

        if (line_end) begin
            col_d = '0;
            row_d = (row_q == '1) ? row_q : row_q + ONE;
        end

`ifdef LB_BORDER_ZERO_EN
        if (accept) begin
            o_win_d = o_win_valid_d ? win_d : '0;
        end else begin
            o_win_d = o_win_q;
        end
`else
        o_win_d = win_d;
`endif
    end

    line_mem #(.PIX_W(PIX_W), .DEPTH(MAX_WIDTH), .AW(AW)) u_lm0 (
        .clk (I_PCLK),
        .we  (accept),
        .addr(addr),
        .wdat(bus.I_PIX),
        .rdat(lm_a)
    );

    line_mem #(.PIX_W(PIX_W), .DEPTH(MAX_WIDTH), .AW(AW)) u_lm1 (
        .clk (I_PCLK),
        .we  (accept),
        .addr(addr),
        .wdat(lm_a),
        .rdat(lm_b)
    );

    always_ff @(posedge I_PCLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            col_q         <= '0;
            row_q         <= '0;
            de_q          <= 1'b0;
            vs_q          <= 1'b0;
            ovf_q         <= 1'b0;
            win_q         <= '0;
            o_win_q       <= '0;
            o_win_valid_q <= 1'b0;
            o_de_q        <= 1'b0;
            o_hsync_q     <= 1'b0;
            o_vsync_q     <= 1'b0;
            o_col_q       <= '0;
            o_row_q       <= '0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            de_q          <= bus.I_DE;
            vs_q          <= bus.I_VSYNC;
            ovf_q         <= ovf_d;
            win_q         <= win_d;
            o_win_q       <= o_win_d;
            o_win_valid_q <= o_win_valid_d;
            o_de_q        <= bus.I_DE;
            o_hsync_q     <= bus.I_HSYNC;
            o_vsync_q     <= bus.I_VSYNC;
            o_col_q       <= o_col_d;
            o_row_q       <= o_row_d;
        end
    end

    assign bus.O_WIN       = o_win_q;
    assign bus.O_WIN_VALID = o_win_valid_q;
    assign bus.O_DE        = o_de_q;
    assign bus.O_HSYNC     = o_hsync_q;
    assign bus.O_VSYNC     = o_vsync_q;
    assign bus.O_COL       = o_col_q;
    assign bus.O_ROW       = o_row_q;
    assign bus.O_OVF       = ovf_q;
endmodule

// File: tb/tb_line_buffer_3x3.sv
// Bench for line_buffer_3x3 with MAX_WIDTH=8: directed steps plus random frames against an image-array model.
// The model keeps the frame as a 2-D pixel array indexed by (row, col) and derives windows from it directly.
module tb_line_buffer_3x3;
    localparam int MW    = 8;
    localparam int CW    = 12;
    localparam int ROWS  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    line_buffer_3x3_if #(.CNT_W(CW)) bus ();

    line_buffer_3x3 #(.MAX_WIDTH(MW), .CNT_W(CW)) dut (
        .I_PCLK (clk),
        .I_RST_N(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0]  img [0:ROWS-1][0:MW-1];
    int          m_col, m_row;
    logic        m_ovf, m_vsp, m_dep;
    int          exp_col, exp_row;
    bit          chk_win = 1'b1;
    int          vcnt;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0; m_ovf = 1'b0; m_vsp = 1'b0; m_dep = 1'b0;
        exp_col = 0; exp_row = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_win"},   bus.O_WIN, 72'h0);
        chk({tag, "_valid"}, 72'(bus.O_WIN_VALID), 72'h0);
        chk({tag, "_de"},    72'(bus.O_DE), 72'h0);
        chk({tag, "_hs"},    72'(bus.O_HSYNC), 72'h0);
        chk({tag, "_vs"},    72'(bus.O_VSYNC), 72'h0);
        chk({tag, "_col"},   72'(bus.O_COL), 72'h0);
        chk({tag, "_row"},   72'(bus.O_ROW), 72'h0);
        chk({tag, "_ovf"},   72'(bus.O_OVF), 72'h0);
    endtask

    // One pixel-clock cycle: drive inputs, advance the model, check outputs 1 ns after the edge.
    task automatic step(input logic [7:0] pix, input logic de, input logic hs, input logic vs);
        bit          fs, acc, ev;
        logic [71:0] ew;
        bus.I_PIX = pix; bus.I_DE = de; bus.I_HSYNC = hs; bus.I_VSYNC = vs;
        fs = vs && !m_vsp;
        if (fs) begin
            m_col = 0; m_row = 0; m_ovf = 1'b0;
        end
        acc = de && (m_col < MW);
        ev  = 1'b0;
        ew  = '0;
        if (acc) begin
            if (m_row < ROWS) img[m_row][m_col] = pix;
            ev      = (m_row >= 2) && (m_col >= 2);
            exp_col = m_col;
            exp_row = m_row;
            if (ev && m_row < ROWS) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew = {ew[63:0], img[m_row-2+i][m_col-2+j]};
            end
            m_col++;
        end else if (de) begin
            m_ovf = 1'b1;
        end
        if (!de && m_dep && !fs) begin
            m_col = 0;
            m_row++;
        end
        m_dep = de;
        m_vsp = vs;

        @(posedge clk);
        #1;
        chk("o_de",    72'(bus.O_DE), 72'(de));
        chk("o_hsync", 72'(bus.O_HSYNC), 72'(hs));
        chk("o_vsync", 72'(bus.O_VSYNC), 72'(vs));
        chk("o_valid", 72'(bus.O_WIN_VALID), 72'(ev));
        chk("o_ovf",   72'(bus.O_OVF), 72'(m_ovf));
        chk("o_col",   72'(bus.O_COL), 72'(exp_col));
        chk("o_row",   72'(bus.O_ROW), 72'(exp_row));
        if (acc) begin
`ifdef LB_BORDER_ZERO_EN
            if (!ev) chk("win_border_zero", bus.O_WIN, 72'h0);
`else
            chk("win_p22", 72'(bus.O_WIN[7:0]), 72'(pix));
`endif
            if (ev && chk_win && m_row < ROWS) chk("win_full", bus.O_WIN, ew);
        end
        if (bus.O_WIN_VALID) vcnt++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.I_PIX = '0; bus.I_DE = 1'b0; bus.I_HSYNC = 1'b0; bus.I_VSYNC = 1'b0;
        model_reset();

        // reset state
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // directed window: 3 lines x 4 pixels, value 16*row+col
        step(8'h00, 1'b0, 1'b0, 1'b1);
        idle(2);
        vcnt = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(8'(16 * r + c), 1'b1, 1'b0, 1'b0);
                if (r == 2 && c == 2) begin
                    chk("win_r2c2", bus.O_WIN, 72'h000102101112202122);
                    chk("win_r2c2_valid", 72'(bus.O_WIN_VALID), 72'h1);
                end
            end
            step(8'h00, 1'b0, 1'b1, 1'b0);
            step(8'h00, 1'b0, 1'b0, 1'b0);
        end
        chk("valid_count", 72'(vcnt), 72'd2);

        // VSYNC rise together with the first pixel
        step(8'h5A, 1'b1, 1'b0, 1'b1);
        chk("vs_de_row", 72'(bus.O_ROW), 72'h0);
        chk("vs_de_col", 72'(bus.O_COL), 72'h0);
        chk("vs_de_valid", 72'(bus.O_WIN_VALID), 72'h0);
        for (int c = 1; c < 4; c++) step(8'($urandom), 1'b1, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        idle(2);

        // overflow: 10-pixel line into an 8-deep line memory
        step(8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        for (int c = 0; c < 10; c++) step(8'(c + 1), 1'b1, 1'b0, 1'b0);
        chk("ovf_col_hold", 72'(bus.O_COL), 72'd7);
        chk("ovf_set", 72'(bus.O_OVF), 72'h1);
        idle(3);
        chk("ovf_sticky", 72'(bus.O_OVF), 72'h1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clear", 72'(bus.O_OVF), 72'h0);
        idle(2);

        // random sync/DE pattern; window contents unconstrained here
        chk_win = 1'b0;
        for (int k = 0; k < 60; k++)
            step(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
        chk_win = 1'b1;
        idle(2);

        // random frames with a constant width per frame
        for (int f = 0; f < 4; f++) begin
            int w, h;
            w = $urandom_range(3, MW);
            h = $urandom_range(3, 6);
            step(8'h00, 1'b0, 1'b0, 1'b1);
            idle($urandom_range(1, 3));
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) step(8'($urandom), 1'b1, 1'($urandom), 1'b0);
                for (int b = 0; b < int'($urandom_range(1, 3)); b++)
                    step(8'($urandom), 1'b0, 1'($urandom), 1'b0);
            end
        end

        // reset in the middle of a line
        step(8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        for (int c = 0; c < 5; c++) step(8'($urandom), 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(8'($urandom), 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        bus.I_DE = 1'b0; bus.I_HSYNC = 1'b0; bus.I_VSYNC = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_hold_valid", 72'(bus.O_WIN_VALID), 72'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        vcnt = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) step(8'($urandom), 1'b1, 1'b0, 1'b0);
            if (r == 1) chk("midrst_no_valid_rows01", 72'(vcnt), 72'h0);
            idle(2);
        end
        chk("midrst_valid_count", 72'(vcnt), 72'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
